// File: rtl/i2s_tx_stream.sv
// I2S / left-justified stereo serial transmitter with a one-pair holding buffer
// between a valid/ready sample source and the external DAC link.
module i2s_tx_stream #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_bclk,
  output logic              o_lrclk,
  output logic              o_sdata,
  output logic              o_frame_start,
  output logic              o_underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PRE_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CNT_W   = $clog2(FRAME_W);

  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(SLOT_W);

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               bclk_q, bclk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic               buf_full_q, buf_full_d;
  logic [DATA_W-1:0]  buf_left_q, buf_left_d;
  logic [DATA_W-1:0]  buf_right_q, buf_right_d;
  logic               frame_start_q, frame_start_d;
  logic               underrun_q, underrun_d;

  logic               tick;
  logic               fall;
  logic               load;
  logic               accept;
  logic [FRAME_W-1:0] frame_img;

  // Place a sample MSB-first in its slot; I2S shifts it one BCLK later than LJ.
  function automatic logic [SLOT_W-1:0] fmt_slot(input logic [DATA_W-1:0] s,
                                                 input logic              lj);
    logic [SLOT_W-1:0] aligned;
    aligned = {s, {(SLOT_W - DATA_W){1'b0}}};
    return lj ? aligned : (aligned >> 1);
  endfunction

  always_comb begin
    tick   = (pre_q == PRE_MAX);
    fall   = tick & bclk_q;
    load   = fall & (cnt_q == CNT_MAX);
    accept = i_valid & ~buf_full_q;
  end

  always_comb begin
    pre_d         = pre_q;
    bclk_d        = bclk_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    sreg_d        = sreg_q;
    buf_full_d    = buf_full_q;
    buf_left_d    = buf_left_q;
    buf_right_d   = buf_right_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    frame_img     = '0;

    if (tick) begin
      pre_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    // Serial outputs only move on falling BCLK so the DAC samples mid-bit.
    if (fall) begin
      if (load) begin
        cnt_d         = '0;
        mode_d        = i_mode;
        frame_start_d = 1'b1;
        if (buf_full_q) begin
          frame_img = {fmt_slot(buf_left_q, i_mode), fmt_slot(buf_right_q, i_mode)};
        end else begin
          underrun_d = 1'b1;
        end
        buf_full_d = 1'b0;
        sdata_d    = frame_img[FRAME_W-1];
        sreg_d     = frame_img << 1;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        sdata_d = sreg_q[FRAME_W-1];
        sreg_d  = sreg_q << 1;
      end
      lrclk_d = (cnt_d >= CNT_RIGHT) ^ mode_d;
    end

    // A pair arriving on the load edge lands after the load saw an empty buffer.
    if (accept) begin
      buf_full_d  = 1'b1;
      buf_left_d  = i_left;
      buf_right_d = i_right;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q         <= '0;
      bclk_q        <= 1'b0;
      cnt_q         <= CNT_MAX;
      mode_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      sreg_q        <= '0;
      buf_full_q    <= 1'b0;
      buf_left_q    <= '0;
      buf_right_q   <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      bclk_q        <= bclk_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      sreg_q        <= sreg_d;
      buf_full_q    <= buf_full_d;
      buf_left_q    <= buf_left_d;
      buf_right_q   <= buf_right_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign o_ready       = ~buf_full_q;
  assign o_bclk        = bclk_q;
  assign o_lrclk       = lrclk_q;
  assign o_sdata       = sdata_q;
  assign o_frame_start = frame_start_q;
  assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Bench for i2s_tx_stream: directed frames are queued as expectations and a
// monitor deserialises every completed frame and checks it against the queue.
module tb_i2s_tx_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, mode, valid;
  logic [15:0] left, right;
  logic        ready, bclk, lrclk, sdata, frameStart, underrun;

  logic        rst24, mode24, valid24;
  logic [23:0] left24, right24;
  logic        ready24, bclk24, lrclk24, sdata24, frameStart24, underrun24;

  i2s_tx_stream #(.DATA_W(16), .SLOT_W(32), .BCLK_DIV(2)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_mode(mode), .i_left(left), .i_right(right),
    .i_valid(valid), .o_ready(ready), .o_bclk(bclk), .o_lrclk(lrclk),
    .o_sdata(sdata), .o_frame_start(frameStart), .o_underrun(underrun)
  );

  i2s_tx_stream #(.DATA_W(24), .SLOT_W(32), .BCLK_DIV(1)) dut24 (
    .i_clk(clk), .i_rst_n(rst24), .i_mode(mode24), .i_left(left24), .i_right(right24),
    .i_valid(valid24), .o_ready(ready24), .o_bclk(bclk24), .o_lrclk(lrclk24),
    .o_sdata(sdata24), .o_frame_start(frameStart24), .o_underrun(underrun24)
  );

  typedef struct {
    logic        frameMode;
    logic [15:0] l;
    logic [15:0] r;
    logic        under;
  } frame_t;

  frame_t sbQueue[$];
  int testsRun = 0;
  int testsFailed = 0;
  int framesChecked = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: expected event did not occur in time", name);
  endtask

  task automatic expectFrame(input logic m, input logic [15:0] l, input logic [15:0] r,
                             input logic u);
    sbQueue.push_back('{m, l, r, u});
  endtask

  // Slot bit k carries sample bit DATA_W-1-(k-d), d = 1 for I2S, 0 for LJ.
  function automatic logic [31:0] slotModel(input logic [15:0] w, input logic lj);
    logic [31:0] v;
    int d;
    v = '0;
    d = lj ? 0 : 1;
    for (int k = 0; k < 32; k++)
      if (k >= d && k - d < 16) v[31-k] = w[15-(k-d)];
    return v;
  endfunction

  task automatic checkFrame(input logic [63:0] dataCap, input logic [63:0] lrCap,
                            input int urCount, input bit periodBad);
    frame_t e;
    if (sbQueue.size() == 0) begin
      flagFail("unexpectedFrame");
      return;
    end
    e = sbQueue.pop_front();
    checkOutput($sformatf("frame%0dData", framesChecked + 1), dataCap,
                {slotModel(e.l, e.frameMode), slotModel(e.r, e.frameMode)});
    checkOutput($sformatf("frame%0dLrclk", framesChecked + 1), lrCap,
                {{32{e.frameMode}}, {32{~e.frameMode}}});
    checkOutput($sformatf("frame%0dUnderrun", framesChecked + 1), 64'(urCount),
                e.under ? 64'd1 : 64'd0);
    checkOutput($sformatf("frame%0dBclkPeriod", framesChecked + 1), 64'(periodBad), 64'd0);
    framesChecked++;
  endtask

  bit          monCapturing;
  int          monBitIdx, monUrCount, monSinceRise;
  bit          monPrevBclk, monPeriodBad, monFirstRise;
  logic [63:0] monData, monLr;

  initial begin : monitor
    monCapturing = 0;
    monPrevBclk  = 0;
    monBitIdx    = 0;
    monUrCount   = 0;
    monSinceRise = 0;
    monPeriodBad = 0;
    monFirstRise = 1;
    monData      = '0;
    monLr        = '0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        monCapturing = 0;
        monPrevBclk  = 0;
      end else begin
        if (frameStart) begin
          if (monCapturing) flagFail("frameLength");
          monCapturing = 1;
          monBitIdx    = 0;
          monUrCount   = 0;
          monPeriodBad = 0;
          monFirstRise = 1;
          monSinceRise = 0;
        end
        if (monCapturing) begin
          if (underrun) monUrCount++;
          monSinceRise++;
          if (bclk && !monPrevBclk) begin
            if (!monFirstRise && monSinceRise != 4) monPeriodBad = 1;
            monFirstRise = 0;
            monSinceRise = 0;
            monData[63-monBitIdx] = sdata;
            monLr[63-monBitIdx]   = lrclk;
            monBitIdx++;
            if (monBitIdx == 64) begin
              checkFrame(monData, monLr, monUrCount, monPeriodBad);
              monCapturing = 0;
            end
          end
        end
        monPrevBclk = bclk;
      end
    end
  end

  // Called on a negedge; holds the pair until accepted and returns one negedge later.
  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input bit hold,
                               output bit readyAtLoad);
    int n;
    n = 0;
    left  = l;
    right = r;
    valid = 1'b1;
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    readyAtLoad = frameStart;
    if (!ready) begin
      flagFail("acceptTimeout");
      valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) valid = 1'b0;
  endtask

  task automatic waitFrameStart;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameStart && n < 1000);
    if (!frameStart) flagFail("frameStartTimeout");
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "Bclk"}, 64'(bclk), 64'd0);
    checkOutput({tag, "Lrclk"}, 64'(lrclk), 64'd0);
    checkOutput({tag, "Sdata"}, 64'(sdata), 64'd0);
    checkOutput({tag, "FrameStart"}, 64'(frameStart), 64'd0);
    checkOutput({tag, "Underrun"}, 64'(underrun), 64'd0);
    checkOutput({tag, "Ready"}, 64'(ready), 64'd1);
  endtask

  initial begin : stimulus
    bit          atLoad;
    int          n, rises, sinceRise;
    bit          bad, prev, sawFs;
    logic [63:0] cap;

    rstN = 1'b1; rst24 = 1'b1;
    mode = 1'b0; valid = 1'b0; left = '0; right = '0;
    mode24 = 1'b0; valid24 = 1'b0; left24 = '0; right24 = '0;
    #1;
    rstN = 1'b0; rst24 = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");

    // F1: I2S A5F0/0F0F buffered before the first load
    rstN = 1'b1;
    expectFrame(1'b0, 16'hA5F0, 16'h0F0F, 1'b0);
    applyStimulus(16'hA5F0, 16'h0F0F, 1'b0, atLoad);
    waitFrameStart();

    // F2: left-justified, same data
    mode = 1'b1;
    expectFrame(1'b1, 16'hA5F0, 16'h0F0F, 1'b0);
    applyStimulus(16'hA5F0, 16'h0F0F, 1'b0, atLoad);
    waitFrameStart();

    // Mode flipped mid-F2 must only show up in F3
    repeat (100) @(negedge clk);
    mode = 1'b0;
    expectFrame(1'b0, 16'h1234, 16'hFEDC, 1'b0);
    applyStimulus(16'h1234, 16'hFEDC, 1'b0, atLoad);
    waitFrameStart();

    // F4, F5 starved
    expectFrame(1'b0, 16'h0000, 16'h0000, 1'b1);
    expectFrame(1'b0, 16'h0000, 16'h0000, 1'b1);
    waitFrameStart();
    waitFrameStart();

    // Backpressure: valid held high across pairs 1..4, one per frame
    for (int i = 1; i <= 4; i++)
      expectFrame(1'b0, 16'(16'h1111 * i), 16'(~(16'h1111 * i)), 1'b0);
    applyStimulus(16'h1111, 16'hEEEE, 1'b1, atLoad);
    checkOutput("readyLowAfterAccept", 64'(ready), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(16'(16'h1111 * i), 16'(~(16'h1111 * i)), 1'b1, atLoad);
      checkOutput($sformatf("pair%0dReadyAtLoad", i), 64'(atLoad), 64'd1);
    end
    valid = 1'b0;

    // F10 starved; pair offered exactly on the F11 load edge lands in F12
    expectFrame(1'b0, 16'h0000, 16'h0000, 1'b1);
    expectFrame(1'b0, 16'h0000, 16'h0000, 1'b1);
    expectFrame(1'b0, 16'h7FFF, 16'h8000, 1'b0);
    waitFrameStart();
    waitFrameStart();
    repeat (255) @(negedge clk);
    left = 16'h7FFF; right = 16'h8000; valid = 1'b1;
    checkOutput("readyBeforeCoincident", 64'(ready), 64'd1);
    @(negedge clk);
    valid = 1'b0;
    checkOutput("coincidentLoad", 64'(frameStart), 64'd1);
    checkOutput("coincidentUnderrun", 64'(underrun), 64'd1);
    checkOutput("coincidentAccepted", 64'(ready), 64'd0);
    waitFrameStart();

    // F13 aborted by reset in its right slot while D sits in the buffer
    waitFrameStart();
    applyStimulus(16'hDEAD, 16'hBEEF, 1'b0, atLoad);
    repeat (170) @(negedge clk);
    checkOutput("midRightSlotLrclk", 64'(lrclk), 64'd1);
    checkOutput("bufferedBeforeReset", 64'(ready), 64'd0);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1 checkReset("midFrameReset");
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    expectFrame(1'b0, 16'h0000, 16'h0000, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameStart && n < 100);
    checkOutput("restartLoadLatency", 64'(n), 64'd4);
    checkOutput("restartUnderrun", 64'(underrun), 64'd1);
    checkOutput("restartReady", 64'(ready), 64'd1);

    n = 0;
    while (framesChecked < 13 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (framesChecked < 13) flagFail("framesCompleted");
    checkOutput("scoreboardEmpty", 64'(sbQueue.size()), 64'd0);
    rstN = 1'b0;

    // 24-bit sample, BCLK_DIV=1, I2S: L=800001, R=7FFFFE
    @(negedge clk);
    rst24 = 1'b1;
    left24 = 24'h800001; right24 = 24'h7FFFFE; valid24 = 1'b1;
    @(negedge clk);
    valid24 = 1'b0;
    n = 0;
    while (!frameStart24 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!frameStart24) flagFail("w24FrameStart");
    checkOutput("w24Underrun", 64'(underrun24), 64'd0);
    prev = bclk24; rises = 0; sinceRise = 0; bad = 0; cap = '0; sawFs = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      sinceRise++;
      if (frameStart24) begin
        sawFs = 1;
        break;
      end
      if (bclk24 && !prev) begin
        if (rises > 0 && sinceRise != 2) bad = 1;
        sinceRise = 0;
        if (rises < 64) cap[63-rises] = sdata24;
        rises++;
      end
      prev = bclk24;
    end
    checkOutput("w24FrameData", cap, 64'h40000080_3FFFFF00);
    checkOutput("w24FrameLength", 64'(rises), 64'd64);
    checkOutput("w24BclkPeriod", 64'(bad), 64'd0);
    checkOutput("w24NextFrame", 64'(sawFs), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
